uart_rx_deframer: RTL and testbench

//   Serial-to-parallel UART receive stage for the SoC's hwreg UART path.
//   - Sits directly upstream of the UART RX queue in the hwreg UART interface.
//   - Synchronises the raw rx pin and detects and validates start bits.
//   - Samples 8N1 frames at mid-bit and emits each received word as a one-cycle

---
 rtl/uart_rx_deframer.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//   Serial-to-parallel UART receive stage for 8N1-style frames (no parity).
//   The raw rx line is synchronised, and a falling edge is treated as a
//   candidate start bit. The start bit is confirmed by sampling it at
//   mid-bit. Each data bit and the stop bit are then sampled once at their
//   mid-bit points.
//   A good frame updates rdata_o and pulses rvalid_o for one cycle.
//   A low stop bit pulses frame_err_o for one cycle. The receiver then
//   waits for the line to return high before it looks for a new start bit.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4)
//   DATA_BITS     data bits per frame, LSB first
//   SYNC_STAGES   flops in the rx_i synchroniser chain (>= 2)
//
// Ports
//   clk_i        in   system clock
//   rst_i        in   asynchronous active-high reset
//   rx_i         in   raw UART line, asynchronous to clk_i, idle high
//   rdata_o      out  last good received word, held until the next good frame
//   rvalid_o     out  one-cycle pulse: rdata_o was updated this cycle
//   frame_err_o  out  one-cycle pulse: the stop bit was sampled low
//   busy_o       out  high while the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 rvalid_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_TERM  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  state_t                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [BIT_W-1:0]       bit_idx_r;
  logic [DATA_BITS-1:0]   sr_r;
  logic [DATA_BITS-1:0]   rdata_r;
  logic                   rvalid_r;
  logic                   ferr_r;
  logic                   busy_r;

  // Synchroniser chain for the asynchronous rx line. It resets to the idle
  // (high) level, so reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign rx_s = sync_r[SYNC_STAGES-1];

  // Receive FSM: start-bit validation, mid-bit sampling and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_idx_r <= '0;
      sr_r      <= '0;
      rdata_r   <= '0;
      rvalid_r  <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      // Pulse outputs default low; they are set only in the one sample cycle.
      rvalid_r <= 1'b0;
      ferr_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end

        START: begin
          // Confirm the start bit at its midpoint. A high line here is a glitch.
          if (cnt_r == HALF_TERM) begin
            cnt_r <= '0;
            if (!rx_s) begin
              state_r   <= DATA;
              bit_idx_r <= '0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt_r == BIT_TERM) begin
            cnt_r     <= '0;
            sr_r      <= {rx_s, sr_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + BIT_W'(1);
            if (bit_idx_r == LAST_BIT) begin
              state_r <= STOP;
            end else begin
              state_r <= DATA;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        STOP: begin
          // Return to IDLE at mid stop bit, so back-to-back frames need no gap.
          if (cnt_r == BIT_TERM) begin
            cnt_r <= '0;
            if (rx_s) begin
              rdata_r  <= sr_r;
              rvalid_r <= 1'b1;
              state_r  <= IDLE;
              busy_r   <= 1'b0;
            end else begin
              ferr_r  <= 1'b1;
              state_r <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        BREAK: begin
          // A line held low (break) must return high before a new start is accepted.
          if (rx_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= BREAK;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata_o     = rdata_r;
  assign rvalid_o    = rvalid_r;
  assign frame_err_o = ferr_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframer
//   Directed self-checking bench for uart_rx_deframer with CLKS_PER_BIT=16,
//   DATA_BITS=8 and SYNC_STAGES=2.
//   Each good frame pushes its expected byte onto a scoreboard queue. A
//   negedge monitor pops the queue on every rvalid_o pulse and compares the
//   popped byte with rdata_o.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam int SS   = 2;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       frame_err_o;
  logic       busy_o;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pulse_cnt   = 0;
  int ferr_cnt    = 0;
  int exp_ferr    = 0;
  int last_pulse_cyc  = 0;
  int frame_start_cyc = 0;
  logic [7:0] exp_q[$];

  uart_rx_deframer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit length in clocks: mode 1 alternates 16/15 (~-3%), mode 2 alternates 16/17 (~+3%).
  function automatic int bit_len(input int i, input int mode);
    if (mode == 1 && (i % 2) == 1) return CPB - 1;
    if (mode == 2 && (i % 2) == 1) return CPB + 1;
    return CPB;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input logic [9:0] bits, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      rx_i = bits[i];
      tick(bit_len(i, mode));
    end
  endtask

  // Drives one frame and leaves rx_i at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int mode);
    frame_start_cyc = cyc;
    if (stop_bit) exp_q.push_back(d);
    else          exp_ferr++;
    drive_bits({stop_bit, d, 1'b0}, 10, mode);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (pulse_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, pulse_cnt, target);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b0) begin
        if (rvalid_o === 1'b1) begin
          pulse_cnt++;
          last_pulse_cyc = cyc;
          check("rvalid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("rdata_scoreboard", {24'd0, rdata_o}, {24'd0, exp_b});
          end
          check("rvalid_ferr_exclusive", {31'd0, frame_err_o}, 32'd0);
        end
        if (frame_err_o === 1'b1) ferr_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] bits;
    logic [9:0] hi;
    int p0;
    int f0;
    int n;

    rst_i = 1'b1;
    rx_i  = 1'b1;
    tick(3);
    check("reset_rdata",  {24'd0, rdata_o},     32'd0);
    check("reset_rvalid", {31'd0, rvalid_o},    32'd0);
    check("reset_ferr",   {31'd0, frame_err_o}, 32'd0);
    check("reset_busy",   {31'd0, busy_o},      32'd0);
    rst_i = 1'b0;
    tick(5);

    // 1: single frame 0xA5 with an exact latency check.
    p0 = pulse_cnt;
    send_frame(8'hA5, 1'b1, 0);
    wait_pulses(p0 + 1, 4 * CPB, "t1_pulse_seen");
    tick(20);
    check("t1_one_pulse", pulse_cnt, p0 + 1);
    check("t1_latency", last_pulse_cyc, frame_start_cyc + SS + 1 + HALF + (DB + 1) * CPB);
    check("t1_rdata", {24'd0, rdata_o}, 32'h0000_00A5);
    check("t1_no_ferr", ferr_cnt, 0);

    // 2: 0x00 then 0xFF back-to-back with zero idle time.
    p0 = pulse_cnt;
    send_frame(8'h00, 1'b1, 0);
    bits = {1'b1, 8'hFF, 1'b0};
    exp_q.push_back(8'hFF);
    drive_bits(bits, 5, 0);
    check("t2_busy_mid", {31'd0, busy_o}, 32'd1);
    hi = bits >> 5;
    drive_bits(hi, 5, 0);
    rx_i = 1'b1;
    wait_pulses(p0 + 2, 4 * CPB, "t2_two_pulses");
    tick(10);
    check("t2_rdata", {24'd0, rdata_o}, 32'h0000_00FF);

    // 3: 4-clock glitch is rejected at the mid-start sample.
    p0 = pulse_cnt;
    f0 = ferr_cnt;
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    check("t3_busy_glitch", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (busy_o === 1'b1 && n < HALF + SS + 2) begin
      tick(1);
      n++;
    end
    check("t3_busy_drop", {31'd0, busy_o}, 32'd0);
    tick(30);
    check("t3_no_rvalid", pulse_cnt, p0);
    check("t3_no_ferr", ferr_cnt, f0);

    // 4: stop bit low, then line held low (break).
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b0, 0);
    tick(40);
    check("t4_ferr", ferr_cnt, exp_ferr);
    check("t4_rdata_held", {24'd0, rdata_o}, 32'h0000_00FF);
    check("t4_busy_break", {31'd0, busy_o}, 32'd1);
    rx_i = 1'b1;
    n = 0;
    while (busy_o === 1'b1 && n < SS + 2) begin
      tick(1);
      n++;
    end
    check("t4_busy_release", {31'd0, busy_o}, 32'd0);
    check("t4_no_rvalid", pulse_cnt, p0);
    tick(10);

    // 5: asynchronous reset during data bit 4 of 0x5A, then 0xC3.
    bits = {1'b1, 8'h5A, 1'b0};
    drive_bits(bits, 5, 0);
    rx_i = bits[5];
    tick(HALF);
    rst_i = 1'b1;
    #1;
    check("t5_rst_rdata",  {24'd0, rdata_o},     32'd0);
    check("t5_rst_rvalid", {31'd0, rvalid_o},    32'd0);
    check("t5_rst_ferr",   {31'd0, frame_err_o}, 32'd0);
    check("t5_rst_busy",   {31'd0, busy_o},      32'd0);
    rx_i = 1'b1;
    tick(10);
    rst_i = 1'b0;
    tick(5);
    p0 = pulse_cnt;
    send_frame(8'hC3, 1'b1, 0);
    wait_pulses(p0 + 1, 4 * CPB, "t5_pulse_seen");
    tick(20);
    check("t5_one_pulse", pulse_cnt, p0 + 1);
    check("t5_rdata", {24'd0, rdata_o}, 32'h0000_00C3);

    // 6: bit-period tolerance, fast (15.5 clk/bit) and slow (16.5 clk/bit).
    p0 = pulse_cnt;
    f0 = ferr_cnt;
    send_frame(8'h96, 1'b1, 1);
    wait_pulses(p0 + 1, 4 * CPB, "t6_fast_pulse");
    tick(5);
    check("t6_fast_rdata", {24'd0, rdata_o}, 32'h0000_0096);
    send_frame(8'h69, 1'b1, 2);
    wait_pulses(p0 + 2, 4 * CPB, "t6_slow_pulse");
    tick(5);
    check("t6_slow_rdata", {24'd0, rdata_o}, 32'h0000_0069);
    check("t6_no_ferr", ferr_cnt, f0);

    tick(20);
    check("queue_drained", exp_q.size(), 0);
    check("ferr_total", ferr_cnt, exp_ferr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
